imem_loader: RTL

//  Write side of the instruction memory. Accepts a byte stream over a valid/ready handshake
//  and packs each 4 bytes little-endian into a 32-bit word. Issues one word write per 4 bytes
//  to the IMem programming port, then checks a trailing checksum byte.

---
 rtl/imem_loader_if.sv | 26 ++
 rtl/imem_loader.sv | 106 ++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMem word-write bundle for imem_loader.
// slave is the loader's view; master is the image source / memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_waddr, mem_wdata, core_hold, done, err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_waddr, mem_wdata, core_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream little-endian into 32-bit IMem word writes,
// verifies a trailing two's-complement checksum byte and holds the core until a good load.
module imem_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned NUM_BYTES = 32
) (
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam int unsigned CntW = ADDR_W + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic [31:0]       buf_q, buf_d;
  logic [7:0]        chk_sum;

  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_waddr_q;
  logic [31:0]       mem_wdata_q;
  logic              core_hold_q;
  logic              done_q;
  logic              err_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    sum_d      = sum_q;
    buf_d      = buf_q;
    chk_sum    = sum_q + bus.in_data;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          sum_d      = '0;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          buf_d[{byte_cnt_q[1:0], 3'b000} +: 8] = bus.in_data;
          sum_d      = sum_q + bus.in_data;
          byte_cnt_d = byte_cnt_q + CntW'(1);
          if (byte_cnt_q[1:0] == 2'd3) state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = (byte_cnt_q == CntW'(NUM_BYTES)) ? CHECK : LOAD;
      end
      CHECK: begin
        if (bus.in_valid) state_d = (chk_sum == 8'd0) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // All outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      sum_q       <= '0;
      buf_q       <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      core_hold_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      sum_q       <= sum_d;
      buf_q       <= buf_d;
      in_ready_q  <= (state_d == LOAD) || (state_d == CHECK);
      mem_we_q    <= (state_d == WRITE);
      if (state_d == WRITE) begin
        mem_waddr_q <= ADDR_W'(byte_cnt_d - CntW'(4));
        mem_wdata_q <= buf_d;
      end
      core_hold_q <= (state_d != DONE);
      done_q      <= (state_d == DONE);
      err_q       <= (state_d == ERR);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_waddr = mem_waddr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.core_hold = core_hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
